trans_allocator_rr: RTL and testbench

TRANS_ALLOCATOR_RR -- requirements
Module: trans_allocator_rr

---
 rtl/trans_allocator_rr.sv | 168 ++++++++++++++++
 tb/tb_trans_allocator_rr.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trans_allocator_rr.sv
`timescale 1ns/1ps
// SID allocator: round-robin core grant of the lowest free SID, combinational and gated only by SID availability.
// Terminations: pend one edge after term_sig_i, then a registered one-cycle evt/int pulse, one SID per cycle. Option: TRANS_ALLOC_FREE_CNT_EN adds free_cnt_o.
module trans_allocator_rr #(
  parameter int NB_CORES        = 4,
  parameter int NB_TRANSFERS    = 8,
  parameter int TRANS_SID_WIDTH = $clog2(NB_TRANSFERS),
  parameter int TRANS_CID_WIDTH = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NB_CORES-1:0]                           trans_req_i,
  output logic [NB_CORES-1:0]                           trans_gnt_o,
  output logic [NB_CORES-1:0][TRANS_SID_WIDTH-1:0]      trans_sid_o,
  input  logic [NB_CORES-1:0][NB_TRANSFERS-1:0]         trans_clr_i,
  output logic [NB_CORES-1:0][NB_TRANSFERS-1:0]         trans_status_o,
  input  logic                                          cmd_req_i,
  input  logic                                          cmd_gnt_i,
  input  logic [TRANS_SID_WIDTH-1:0]                    cmd_sid_i,
  input  logic [TRANS_CID_WIDTH-1:0]                    cmd_cid_i,
  input  logic                                          cmd_ele_i,
  input  logic                                          cmd_ile_i,
  input  logic                                          cmd_ble_i,
  input  logic [NB_TRANSFERS-1:0]                       term_sig_i,
  output logic [NB_CORES-1:0]                           term_evt_o,
  output logic [NB_CORES-1:0]                           term_int_o
`ifdef TRANS_ALLOC_FREE_CNT_EN
  ,
  output logic [$clog2(NB_TRANSFERS+1)-1:0]             free_cnt_o
`endif
);

  localparam int CPW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

  typedef struct packed {
    logic [TRANS_CID_WIDTH-1:0] cid;
    logic                       ele;
    logic                       ile;
    logic                       ble;
  } rec_t;

  logic [NB_TRANSFERS-1:0]    busy_q, busy_nxt, pend_q, clr_any, set_vec, serve_clr;
  rec_t                       record_q [NB_TRANSFERS];
  rec_t                       tbuf_q   [NB_TRANSFERS];
  rec_t                       serve_rec;
  logic [CPW-1:0]             alloc_ptr_q, gnt_idx, cand;
  logic [TRANS_SID_WIDTH-1:0] serve_ptr_q, free_sid, serve_sid, scand;
  logic                       free_vld, gnt_vld, serve_vld;
  logic [NB_CORES-1:0]        evt_nxt, int_nxt;

  // Descending scan leaves the lowest free index in free_sid.
  always_comb begin
    free_vld = 1'b0;
    free_sid = '0;
    for (int s = NB_TRANSFERS - 1; s >= 0; s--) begin
      if (!busy_q[s]) begin
        free_vld = 1'b1;
        free_sid = TRANS_SID_WIDTH'(s);
      end
    end
  end

  // alloc_ptr_q holds the next core to consider, so reset value 0 favours core 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      cand = CPW'((int'(alloc_ptr_q) + i) % NB_CORES);
      if (!gnt_vld && trans_req_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vld = gnt_vld & free_vld & !rst_i;
  end

  always_comb begin
    trans_gnt_o = '0;
    if (gnt_vld) trans_gnt_o[gnt_idx] = 1'b1;
    set_vec = '0;
    if (gnt_vld) set_vec[free_sid] = 1'b1;
    clr_any = '0;
    for (int c = 0; c < NB_CORES; c++) clr_any = clr_any | trans_clr_i[c];
    busy_nxt = (busy_q & ~clr_any) | set_vec;
    for (int c = 0; c < NB_CORES; c++) begin
      trans_sid_o[c]    = free_sid;
      trans_status_o[c] = busy_q;
    end
  end

  always_comb begin
    serve_vld = 1'b0;
    serve_sid = '0;
    scand     = '0;
    for (int i = 0; i < NB_TRANSFERS; i++) begin
      scand = TRANS_SID_WIDTH'((int'(serve_ptr_q) + i) % NB_TRANSFERS);
      if (!serve_vld && pend_q[scand]) begin
        serve_vld = 1'b1;
        serve_sid = scand;
      end
    end
    serve_clr = '0;
    if (serve_vld) serve_clr[serve_sid] = 1'b1;
  end

  // Broadcast records hit every core; directed ones only their own cid, if it exists.
  always_comb begin
    evt_nxt   = '0;
    int_nxt   = '0;
    serve_rec = tbuf_q[serve_sid];
    if (serve_vld) begin
      if (serve_rec.ble) begin
        evt_nxt = {NB_CORES{serve_rec.ele}};
        int_nxt = {NB_CORES{serve_rec.ile}};
      end else if (int'(serve_rec.cid) < NB_CORES) begin
        evt_nxt[serve_rec.cid] = serve_rec.ele;
        int_nxt[serve_rec.cid] = serve_rec.ile;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      pend_q      <= '0;
      alloc_ptr_q <= '0;
      serve_ptr_q <= '0;
      term_evt_o  <= '0;
      term_int_o  <= '0;
      for (int s = 0; s < NB_TRANSFERS; s++) begin
        record_q[s] <= '0;
        tbuf_q[s]   <= '0;
      end
    end else begin
      busy_q <= busy_nxt;
      if (gnt_vld) alloc_ptr_q <= CPW'((int'(gnt_idx) + 1) % NB_CORES);
      if (cmd_req_i && cmd_gnt_i)
        record_q[cmd_sid_i] <= '{cid: cmd_cid_i, ele: cmd_ele_i, ile: cmd_ile_i, ble: cmd_ble_i};
      // A fresh termination on the served SID re-arms pend with the newer record.
      for (int s = 0; s < NB_TRANSFERS; s++) begin
        if (term_sig_i[s]) tbuf_q[s] <= record_q[s];
      end
      pend_q <= (pend_q & ~serve_clr) | term_sig_i;
      if (serve_vld) serve_ptr_q <= TRANS_SID_WIDTH'((int'(serve_sid) + 1) % NB_TRANSFERS);
      term_evt_o <= evt_nxt;
      term_int_o <= int_nxt;
    end
  end

`ifdef TRANS_ALLOC_FREE_CNT_EN
  localparam int FCW = $clog2(NB_TRANSFERS + 1);
  logic [FCW-1:0] free_nxt;

  always_comb begin
    free_nxt = '0;
    for (int s = 0; s < NB_TRANSFERS; s++) begin
      if (!busy_nxt[s]) free_nxt = free_nxt + FCW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    free_cnt_o <= FCW'(NB_TRANSFERS);
    else if (busy_nxt != busy_q)  free_cnt_o <= free_nxt;
  end
`endif

endmodule

// File: tb/tb_trans_allocator_rr.sv
`timescale 1ns/1ps
// Directed bench for trans_allocator_rr; termination pulses are matched against a queue of expected pulses.
module tb_trans_allocator_rr;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [3:0]            trans_req_i;
  logic [3:0]            trans_gnt_o;
  logic [3:0][2:0]       trans_sid_o;
  logic [3:0][7:0]       trans_clr_i;
  logic [3:0][7:0]       trans_status_o;
  logic                  cmd_req_i, cmd_gnt_i;
  logic [2:0]            cmd_sid_i;
  logic [1:0]            cmd_cid_i;
  logic                  cmd_ele_i, cmd_ile_i, cmd_ble_i;
  logic [7:0]            term_sig_i;
  logic [3:0]            term_evt_o, term_int_o;
`ifdef TRANS_ALLOC_FREE_CNT_EN
  logic [3:0]            free_cnt_o;
`endif

  typedef struct packed {
    logic [3:0] evt;
    logic [3:0] irq;
  } pulse_t;

  pulse_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  trans_allocator_rr dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .trans_req_i    (trans_req_i),
    .trans_gnt_o    (trans_gnt_o),
    .trans_sid_o    (trans_sid_o),
    .trans_clr_i    (trans_clr_i),
    .trans_status_o (trans_status_o),
    .cmd_req_i      (cmd_req_i),
    .cmd_gnt_i      (cmd_gnt_i),
    .cmd_sid_i      (cmd_sid_i),
    .cmd_cid_i      (cmd_cid_i),
    .cmd_ele_i      (cmd_ele_i),
    .cmd_ile_i      (cmd_ile_i),
    .cmd_ble_i      (cmd_ble_i),
    .term_sig_i     (term_sig_i),
    .term_evt_o     (term_evt_o),
    .term_int_o     (term_int_o)
`ifdef TRANS_ALLOC_FREE_CNT_EN
    ,
    .free_cnt_o     (free_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cmd_wr(input logic [2:0] sid, input logic [1:0] cid,
                        input logic ele, input logic ile, input logic ble);
    cmd_sid_i = sid; cmd_cid_i = cid;
    cmd_ele_i = ele; cmd_ile_i = ile; cmd_ble_i = ble;
    cmd_req_i = 1'b1; cmd_gnt_i = 1'b1;
    tick();
    cmd_req_i = 1'b0; cmd_gnt_i = 1'b0;
  endtask

  // Every nonzero pulse must match the oldest queued expectation.
  always begin
    @(posedge clk_i);
    #2;
    if (term_evt_o !== 4'b0 || term_int_o !== 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'({term_evt_o, term_int_o}), 64'(0));
      end else begin
        pulse_t e;
        e = exp_q.pop_front();
        chk("sb_evt", 64'(term_evt_o), 64'(e.evt));
        chk("sb_int", 64'(term_int_o), 64'(e.irq));
      end
    end
  end

  initial begin
    logic [3:0][2:0] es;
    rst_i = 1'b1;
    trans_req_i = '0; trans_clr_i = '0; term_sig_i = '0;
    cmd_req_i = 1'b0; cmd_gnt_i = 1'b0; cmd_sid_i = '0; cmd_cid_i = '0;
    cmd_ele_i = 1'b0; cmd_ile_i = 1'b0; cmd_ble_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_gnt", 64'(trans_gnt_o), 64'(0));
    chk("rst_status", 64'(trans_status_o), 64'(0));
    chk("rst_evt", 64'(term_evt_o), 64'(0));
    chk("rst_int", 64'(term_int_o), 64'(0));
`ifdef TRANS_ALLOC_FREE_CNT_EN
    chk("rst_free_cnt", 64'(free_cnt_o), 64'(8));
`endif

    // Cores 0 and 2 alternate, taking SIDs in ascending order until all are busy.
    rst_i = 1'b0;
    trans_req_i = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      #1;
      es = {4{3'(k)}};
      chk("rr_gnt", 64'(trans_gnt_o), 64'((k % 2 == 0) ? 4'b0001 : 4'b0100));
      chk("rr_sid", 64'(es), 64'(trans_sid_o));
      tick();
    end
    trans_req_i = '0;
    chk("all_busy_status", 64'(trans_status_o), 64'({4{8'hFF}}));
`ifdef TRANS_ALLOC_FREE_CNT_EN
    chk("free_cnt_zero", 64'(free_cnt_o), 64'(0));
`endif

    // Full table: no grant, SID 0; a release of SID 5 by core 3 lets core 1 in.
    trans_req_i = 4'b0010;
    #1;
    chk("full_gnt", 64'(trans_gnt_o), 64'(0));
    chk("full_sid", 64'(trans_sid_o), 64'(0));
    trans_clr_i[3] = 8'h20;
    tick();
    trans_clr_i = '0;
    #1;
    chk("freed_gnt", 64'(trans_gnt_o), 64'(4'b0010));
    chk("freed_sid", 64'(trans_sid_o), 64'({4{3'd5}}));
    chk("freed_status", 64'(trans_status_o), 64'({4{8'hDF}}));
    tick();
    trans_req_i = '0;
    chk("realloc_status", 64'(trans_status_o), 64'({4{8'hFF}}));
    trans_clr_i[0] = 8'hFF;
    tick();
    trans_clr_i = '0;
    chk("clr_all_status", 64'(trans_status_o), 64'(0));

    // Directed event to core 2 only, with exact pulse timing.
    cmd_wr(3'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    term_sig_i = 8'h08;
    exp_q.push_back('{evt: 4'b0100, irq: 4'b0000});
    tick();
    term_sig_i = '0;
    chk("lat_early_evt", 64'(term_evt_o), 64'(0));
    tick();
    chk("lat_evt", 64'(term_evt_o), 64'(4'b0100));
    chk("lat_int", 64'(term_int_o), 64'(0));
    tick();
    chk("pulse_one_cycle", 64'(term_evt_o), 64'(0));

    // Reset while two terminations are pending drops them entirely.
    cmd_wr(3'd1, 2'd0, 1'b1, 1'b1, 1'b1);
    cmd_wr(3'd4, 2'd0, 1'b1, 1'b1, 1'b1);
    trans_req_i = 4'b0001;
    term_sig_i = 8'h12;
    tick();
    trans_req_i = '0;
    term_sig_i = '0;
    rst_i = 1'b1;
    #1;
    chk("midrst_status", 64'(trans_status_o), 64'(0));
    tick();
    tick();
    rst_i = 1'b0;
    repeat (4) begin
      tick();
      chk("post_rst_evt", 64'(term_evt_o), 64'(0));
      chk("post_rst_int", 64'(term_int_o), 64'(0));
    end
    chk("post_rst_status", 64'(trans_status_o), 64'(0));
`ifdef TRANS_ALLOC_FREE_CNT_EN
    chk("post_rst_free_cnt", 64'(free_cnt_o), 64'(8));
`endif
    trans_req_i = 4'b1111;
    #1;
    chk("first_gnt_after_rst", 64'(trans_gnt_o), 64'(4'b0001));
    chk("first_sid_after_rst", 64'(trans_sid_o), 64'(0));
    tick();
    trans_req_i = '0;
    trans_clr_i[0] = 8'h01;
    tick();
    trans_clr_i = '0;

    // Three broadcasts in one cycle come out back to back in SID order 0,2,7 (int tells 2 apart).
    cmd_wr(3'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    cmd_wr(3'd2, 2'd0, 1'b1, 1'b0, 1'b1);
    cmd_wr(3'd7, 2'd0, 1'b1, 1'b1, 1'b1);
    exp_q.push_back('{evt: 4'b1111, irq: 4'b1111});
    exp_q.push_back('{evt: 4'b1111, irq: 4'b0000});
    exp_q.push_back('{evt: 4'b1111, irq: 4'b1111});
    term_sig_i = 8'h85;
    tick();
    term_sig_i = '0;
    tick();
    chk("bc0_evt", 64'(term_evt_o), 64'(4'b1111));
    chk("bc0_int", 64'(term_int_o), 64'(4'b1111));
    tick();
    chk("bc2_evt", 64'(term_evt_o), 64'(4'b1111));
    chk("bc2_int", 64'(term_int_o), 64'(4'b0000));
    tick();
    chk("bc7_evt", 64'(term_evt_o), 64'(4'b1111));
    chk("bc7_int", 64'(term_int_o), 64'(4'b1111));
    tick();
    chk("bc_done_evt", 64'(term_evt_o), 64'(0));

    // Re-termination on the serve cycle yields a second pulse with the updated record.
    cmd_wr(3'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    term_sig_i = 8'h02;
    cmd_sid_i = 3'd1; cmd_cid_i = 2'd3;
    cmd_ele_i = 1'b0; cmd_ile_i = 1'b1; cmd_ble_i = 1'b0;
    cmd_req_i = 1'b1; cmd_gnt_i = 1'b1;
    exp_q.push_back('{evt: 4'b0010, irq: 4'b0000});
    tick();
    cmd_req_i = 1'b0; cmd_gnt_i = 1'b0;
    term_sig_i = 8'h02;
    exp_q.push_back('{evt: 4'b0000, irq: 4'b1000});
    tick();
    term_sig_i = '0;
    chk("retrig_a_evt", 64'(term_evt_o), 64'(4'b0010));
    chk("retrig_a_int", 64'(term_int_o), 64'(0));
    tick();
    chk("retrig_b_evt", 64'(term_evt_o), 64'(0));
    chk("retrig_b_int", 64'(term_int_o), 64'(4'b1000));
    tick();
    chk("retrig_done_int", 64'(term_int_o), 64'(0));

    repeat (2) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
